// File: rtl/midi_rx.sv
// -----------------------------------------------------------------------------
// midi_rx
//
// MIDI-in receiver. Deserialises the 31.25 kbaud 8N1 stream from the
// opto-isolated input pin and assembles complete channel-voice messages into
// a single 24-bit word for the synth control block.
//
// Handles:
//   - running status (repeated data pairs without resending status)
//   - real-time bytes (0xF8-0xFF) interleaved anywhere, ignored transparently
//   - system common / SysEx (0xF0-0xF7), which cancels running status
//   - Note On with velocity 0, re-emitted as the matching Note Off
//
// Parameters:
//   BAUD_DIV    clk_in cycles per MIDI bit (98.3 MHz / 31250 ~= 3146), >= 8
//
// Ports:
//   clk_in       system clock
//   rst_in       synchronous, active-high reset
//   midi_rx_in   raw serial line, asynchronous to clk_in, idle high
//   midi_event   last complete message: [23:16] status, [15:8] data1,
//                [7:0] data2; held until the next message completes
//   event_valid  one-cycle pulse in the cycle midi_event is updated
//   frame_err    one-cycle pulse when a byte ends with a low stop bit
// -----------------------------------------------------------------------------
module midi_rx #(
  parameter  int BAUD_DIV   = 3146,
  localparam int MIDI_BYTES = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  midi_rx_in,
  output logic [MIDI_BYTES-1:0] midi_event,
  output logic                  event_valid,
  output logic                  frame_err
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(BAUD_DIV);

  // Half a bit from the detected start edge lands in the middle of the start
  // bit; every full bit after that lands in the middle of the next bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and falling-edge detector
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic start_edge;

  // Everything resets to the idle-line level so that releasing reset while the
  // line is high never looks like a start bit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // the chain samples its pre-edge value and the chain really is 3 deep.
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= midi_rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------------
  // Bit receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_t        state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [2:0]       bit_cnt_q,    bit_cnt_d;
  logic [7:0]       shift_q,      shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q,  frame_err_d;
  logic             cnt_zero;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_START;
          cnt_d     = HALF_LOAD;
          bit_cnt_d = '0;
        end
      end

      S_START: begin
        if (cnt_zero) begin
          // A start bit that has already gone high by mid-bit was a glitch.
          if (!rx_sync) begin
            state_d = S_DATA;
            cnt_d   = FULL_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_zero) begin
          // LSB arrives first, so shift in from the top.
          shift_d   = {rx_sync, shift_q[7:1]};
          cnt_d     = FULL_LOAD;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_zero) begin
          // Returning to IDLE at mid-stop-bit leaves half a bit of margin for
          // a back-to-back start edge.
          state_d = S_IDLE;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Message parser
  // ---------------------------------------------------------------------------
  logic [7:0] run_status_q;
  logic       run_valid_q;
  logic       data_idx_q;
  logic [7:0] data1_q;
  logic       one_data_byte;

  // Program Change (0xCn) and Channel Pressure (0xDn) carry one data byte.
  assign one_data_byte = (run_status_q[7:5] == 3'b110);

  // Builds the output word; a Note On with velocity 0 is reported as the
  // equivalent Note Off on the same channel.
  function automatic logic [MIDI_BYTES-1:0] make_event(input logic [7:0] status,
                                                       input logic [7:0] d1,
                                                       input logic [7:0] d2);
    logic [7:0] st;
    st = status;
    if ((status[7:4] == 4'h9) && (d2 == 8'h00)) begin
      st = {4'h8, status[3:0]};
    end
    return {st, d1, d2};
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      run_status_q <= '0;
      run_valid_q  <= 1'b0;
      data_idx_q   <= 1'b0;
      data1_q      <= '0;
      midi_event   <= '0;
      event_valid  <= 1'b0;
    end else begin
      event_valid <= 1'b0;

      if (byte_valid_q) begin
        if (shift_q[7]) begin
          if (shift_q[7:4] == 4'hF) begin
            // 0xF8-0xFF real-time: no effect at all, so a clock tick can sit
            // between data bytes of a message. 0xF0-0xF7 cancels running
            // status so SysEx payload bytes are dropped.
            if (!shift_q[3]) begin
              run_valid_q <= 1'b0;
              data_idx_q  <= 1'b0;
            end
          end else begin
            run_status_q <= shift_q;
            run_valid_q  <= 1'b1;
            data_idx_q   <= 1'b0;
          end
        end else if (run_valid_q) begin
          if (!data_idx_q) begin
            data1_q <= shift_q;
            if (one_data_byte) begin
              midi_event  <= make_event(run_status_q, shift_q, 8'h00);
              event_valid <= 1'b1;
            end else begin
              data_idx_q <= 1'b1;
            end
          end else begin
            // Index wraps to 0 so the next data pair reuses running status.
            midi_event  <= make_event(run_status_q, data1_q, shift_q);
            event_valid <= 1'b1;
            data_idx_q  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_rx.sv
// -----------------------------------------------------------------------------
// tb_midi_rx
//
// Directed bench for midi_rx at BAUD_DIV = 16. Serial frames are driven bit by
// bit; each message the bench expects is pushed to a scoreboard queue together
// with the clock cycle at which event_valid must be seen. A monitor pops the
// queue on every event_valid pulse and compares word and timing.
// -----------------------------------------------------------------------------
module tb_midi_rx;

  localparam int BIT = 16;
  // Line fall -> event_valid: 3 cycles to detect the edge, 8 to mid start bit,
  // 9 * 16 to the stop-bit decision, 1 for byte_valid.
  localparam int EVENT_LAT = 3 + 8 + 9 * BIT + 1;

  logic        clk_in;
  logic        rst_in;
  logic        midi_rx_in;
  logic [23:0] midi_event;
  logic        event_valid;
  logic        frame_err;

  midi_rx #(.BAUD_DIV(BIT)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .midi_rx_in  (midi_rx_in),
    .midi_event  (midi_event),
    .event_valid (event_valid),
    .frame_err   (frame_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  typedef struct {
    logic [23:0] word;
    int          due_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks       = 0;
  int   errors       = 0;
  int   ferr_pending = 0;
  int   ferr_seen    = 0;
  int   ev_seen      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Must be entered at a negedge; returns at a negedge, so calls chain with no
  // idle time between stop bit and the next start bit.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                           input bit has_exp, input logic [23:0] exp_word);
    midi_rx_in = 1'b0;
    if (has_exp) sb.push_back('{word: exp_word, due_cyc: cyc + EVENT_LAT});
    repeat (BIT) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      midi_rx_in = b[i];
      repeat (BIT) @(negedge clk_in);
    end
    midi_rx_in = stop_ok;
    if (!stop_ok) ferr_pending++;
    repeat (BIT) @(negedge clk_in);
    midi_rx_in = 1'b1;
  endtask

  task automatic tx(input logic [7:0] b);
    send_byte(b, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic tx_ev(input logic [7:0] b, input logic [23:0] w);
    send_byte(b, 1'b1, 1'b1, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk_in) begin
    if (event_valid) begin
      ev_seen++;
      check("event_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("event_word", 32'(midi_event), 32'(mon_e.word));
        check("event_cycle", 32'(cyc), 32'(mon_e.due_cyc));
      end
    end
    if (frame_err) begin
      ferr_seen++;
      check("frame_err_expected", 32'(ferr_pending > 0), 32'd1);
      if (ferr_pending > 0) ferr_pending--;
    end
  end

  initial begin
    rst_in     = 1'b1;
    midi_rx_in = 1'b1;
    idle(4);
    check("reset_event", 32'(midi_event), 32'h0);
    check("reset_valid", 32'(event_valid), 32'h0);
    check("reset_ferr",  32'(frame_err), 32'h0);
    rst_in = 1'b0;
    idle(4);

    // Basic Note On.
    tx(8'h90); tx(8'h3C); tx_ev(8'h64, 24'h903C64);
    idle(8);
    check("basic_drained", 32'(sb.size()), 32'd0);

    // Running status.
    tx(8'h90); tx(8'h3C); tx_ev(8'h64, 24'h903C64);
    tx(8'h40); tx_ev(8'h50, 24'h904050);
    idle(8);
    check("running_drained", 32'(sb.size()), 32'd0);

    // Velocity 0 with a timing clock between the data bytes; other channel.
    tx(8'h90); tx(8'h3C); tx(8'hF8); tx_ev(8'h00, 24'h803C00);
    tx(8'h9A); tx(8'h10); tx_ev(8'h00, 24'h8A1000);
    idle(8);
    check("vel0_drained", 32'(sb.size()), 32'd0);

    // Pitch bend, program change, then SysEx and a stray data byte.
    tx(8'hE0); tx(8'h00); tx_ev(8'h7F, 24'hE0007F);
    tx(8'hC0); tx_ev(8'h05, 24'hC00500);
    tx(8'hF0); tx(8'h11); tx(8'h22); tx(8'hF7); tx(8'h22);
    idle(8);
    check("sysex_drained", 32'(sb.size()), 32'd0);
    check("sysex_word_held", 32'(midi_event), 32'hC00500);

    // Bad stop bit on data1, then a clean Note Off.
    tx(8'h90);
    send_byte(8'h3C, 1'b0, 1'b0, 24'h0);
    idle(2 * BIT);
    tx(8'h64);
    tx(8'h80); tx(8'h3C); tx_ev(8'h00, 24'h803C00);
    idle(8);
    check("ferr_drained", 32'(sb.size()), 32'd0);
    check("ferr_count", 32'(ferr_seen), 32'd1);

    // Short low glitch between data bytes must not start a frame.
    tx(8'h90); tx(8'h3C);
    midi_rx_in = 1'b0;
    idle(3);
    midi_rx_in = 1'b1;
    idle(40);
    tx_ev(8'h64, 24'h903C64);
    idle(8);
    check("glitch_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a byte, running status previously set.
    tx(8'h90);
    midi_rx_in = 1'b0;
    idle(3 * BIT);
    rst_in = 1'b1;
    idle(3);
    check("midrst_event", 32'(midi_event), 32'h0);
    check("midrst_valid", 32'(event_valid), 32'h0);
    check("midrst_ferr",  32'(frame_err), 32'h0);
    midi_rx_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
    idle(2 * BIT);
    tx(8'h40); tx(8'h50);
    idle(2 * BIT);
    check("midrst_no_event", 32'(midi_event), 32'h0);

    check("final_sb_empty",     32'(sb.size()), 32'd0);
    check("final_ferr_pending", 32'(ferr_pending), 32'd0);
    check("final_event_count",  32'(ev_seen), 32'd9);
    check("final_ferr_count",   32'(ferr_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
